// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the SAP-2 memory access sequencer.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    localparam logic [15:0] MAR_RST = 16'h0000;

endpackage

// File: rtl/mar_reg.sv
// Memory address register: load from the W-bus or increment with natural wrap.
module mar_reg #(
    parameter int                ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] RST_VAL = '0
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iEn,
    input  logic              iLoad,
    input  logic              iInc,
    input  logic [ADDR_W-1:0] iD,
    output logic [ADDR_W-1:0] oQ
);

    // Load wins over increment; the add wraps at the top of the address space.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN)
            oQ <= RST_VAL;
        else if (iEn) begin
            if (iLoad)
                oQ <= iD;
            else if (iInc)
                oQ <= oQ + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Read/write sequencer between the W-bus/MDR and external RAM with wait states.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_STATES = 1,
    parameter int CNT_W       = 4
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic [15:0]       iwBus,
    input  logic              iLmar,
    input  logic              iInc,
    input  logic              iReq,
    input  logic              iWr,
    input  logic [DATA_W-1:0] iWdata,
    output logic [DATA_W-1:0] oRdata,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic              oMemRe,
    output logic              oMemWe,
    output logic [DATA_W-1:0] oMemWdata,
    input  logic [DATA_W-1:0] iMemRdata
);

    state_t             state, nextState;
    logic [CNT_W-1:0]   waitCnt;
    logic               wrType;
    logic               lastCycle;

    assign lastCycle = (waitCnt == '0);

    // Strobes and flags decode straight from state so reset clears them without an edge.
    assign oBusy  = (state != IDLE);
    assign oDone  = (state == DONE);
    assign oMemRe = (state == ACCESS) && !wrType;
    assign oMemWe = (state == ACCESS) &&  wrType;

    mar_reg #(
        .ADDR_W  (ADDR_W),
        .RST_VAL (MAR_RST[ADDR_W-1:0])
    ) uMar (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iEn   (!oBusy),
        .iLoad (iLmar),
        .iInc  (iInc),
        .iD    (iwBus[ADDR_W-1:0]),
        .oQ    (oMemAddr)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (iReq)      nextState = ACCESS;
            ACCESS:  if (lastCycle) nextState = DONE;
            DONE:                   nextState = IDLE;
            default:                nextState = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            waitCnt   <= '0;
            wrType    <= 1'b0;
            oRdata    <= '0;
            oMemWdata <= '0;
            oErr      <= 1'b0;
        end else begin
            oErr <= oBusy && (iReq || iLmar || iInc);
            if (state == IDLE && iReq) begin
                wrType    <= iWr;
                oMemWdata <= iWdata;
                waitCnt   <= CNT_W'(WAIT_STATES);
            end else if (state == ACCESS) begin
                if (lastCycle) begin
                    if (!wrType)
                        oRdata <= iMemRdata;
                end else
                    waitCnt <= waitCnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with WAIT_STATES=1; inputs and checks on the falling edge.
module tb_mem_access_ctrl;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic [15:0] iwBus;
    logic        iLmar, iInc, iReq, iWr;
    logic [7:0]  iWdata;
    logic [7:0]  oRdata;
    logic        oBusy, oDone, oErr;
    logic [15:0] oMemAddr;
    logic        oMemRe, oMemWe;
    logic [7:0]  oMemWdata;
    logic [7:0]  iMemRdata;

    int nCmp = 0;
    int nErr = 0;

    mem_access_ctrl #(
        .ADDR_W      (16),
        .DATA_W      (8),
        .WAIT_STATES (1),
        .CNT_W       (4)
    ) dut (
        .iClk      (iClk),
        .iRstN     (iRstN),
        .iwBus     (iwBus),
        .iLmar     (iLmar),
        .iInc      (iInc),
        .iReq      (iReq),
        .iWr       (iWr),
        .iWdata    (iWdata),
        .oRdata    (oRdata),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oErr      (oErr),
        .oMemAddr  (oMemAddr),
        .oMemRe    (oMemRe),
        .oMemWe    (oMemWe),
        .oMemWdata (oMemWdata),
        .iMemRdata (iMemRdata)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        @(negedge iClk);
    endtask

    initial begin
        iRstN = 1'b0; iwBus = '0; iLmar = 0; iInc = 0; iReq = 0; iWr = 0;
        iWdata = '0; iMemRdata = '0;
        step();
        chk("rst_addr",  oMemAddr, 16'h0000);
        chk("rst_rdata", oRdata, 8'h00);
        chk("rst_flags", {oBusy, oDone, oErr, oMemRe, oMemWe}, 5'b0);
        iRstN = 1'b1;
        step();
        chk("idle_flags", {oBusy, oDone, oErr, oMemRe, oMemWe}, 5'b0);

        // Read at 0x1234 returning 0xA5
        iLmar = 1; iwBus = 16'h1234;
        step();
        iLmar = 0;
        chk("rd_mar", oMemAddr, 16'h1234);
        iReq = 1; iWr = 0; iMemRdata = 8'hA5;
        step();
        iReq = 0;
        chk("rd_n1", {oBusy, oDone, oMemRe, oMemWe}, 4'b1010);
        chk("rd_n1_addr", oMemAddr, 16'h1234);
        step();
        chk("rd_n2", {oBusy, oDone, oMemRe, oMemWe}, 4'b1010);
        chk("rd_n2_addr", oMemAddr, 16'h1234);
        step();
        chk("rd_n3", {oBusy, oDone, oMemRe, oMemWe}, 4'b1100);
        chk("rd_data", oRdata, 8'hA5);
        step();
        chk("rd_n4", {oBusy, oDone, oMemRe, oMemWe}, 4'b0000);

        // Write 0x3C at 0x00FF
        iLmar = 1; iwBus = 16'h00FF;
        step();
        iLmar = 0;
        iReq = 1; iWr = 1; iWdata = 8'h3C; iMemRdata = 8'h77;
        step();
        iReq = 0; iWdata = 8'h00;
        chk("wr_n1", {oBusy, oDone, oMemRe, oMemWe}, 4'b1001);
        chk("wr_wdata", oMemWdata, 8'h3C);
        chk("wr_addr", oMemAddr, 16'h00FF);
        step();
        chk("wr_n2", {oBusy, oDone, oMemRe, oMemWe}, 4'b1001);
        step();
        chk("wr_n3", {oBusy, oDone, oMemRe, oMemWe}, 4'b1100);
        chk("wr_rdata_kept", oRdata, 8'hA5);
        step();
        chk("wr_n4", {oBusy, oDone, oMemRe, oMemWe}, 4'b0000);

        // Increment wrap and load-over-increment priority
        iLmar = 1; iwBus = 16'hFFFF;
        step();
        iLmar = 0;
        chk("mar_ffff", oMemAddr, 16'hFFFF);
        iInc = 1;
        step();
        iInc = 0;
        chk("inc_wrap", oMemAddr, 16'h0000);
        iLmar = 1; iInc = 1; iwBus = 16'h0042;
        step();
        iLmar = 0; iInc = 0;
        chk("lmar_prio", oMemAddr, 16'h0042);

        // Collisions while busy
        iReq = 1; iWr = 0; iMemRdata = 8'h5A;
        step();
        iReq = 0;
        chk("col_n1", {oBusy, oErr, oMemRe}, 3'b101);
        iLmar = 1; iwBus = 16'h9999;
        step();
        iLmar = 0;
        chk("col_n2", {oBusy, oErr, oMemRe, oDone}, 4'b1110);
        chk("col_n2_addr", oMemAddr, 16'h0042);
        iInc = 1;
        step();
        iInc = 0;
        chk("col_n3", {oBusy, oErr, oMemRe, oDone}, 4'b1101);
        chk("col_n3_addr", oMemAddr, 16'h0042);
        chk("col_rdata", oRdata, 8'h5A);
        iReq = 1; iWr = 1;
        step();
        iReq = 0; iWr = 0;
        chk("col_n4", {oBusy, oErr, oMemRe, oMemWe, oDone}, 5'b01000);
        chk("col_n4_addr", oMemAddr, 16'h0042);
        step();
        chk("col_n5", {oBusy, oErr, oMemRe, oMemWe, oDone}, 5'b00000);

        // Reset asserted mid-write
        iLmar = 1; iwBus = 16'h7777;
        step();
        iLmar = 0;
        iReq = 1; iWr = 1; iWdata = 8'h11;
        step();
        iReq = 0;
        chk("mid_we", oMemWe, 1'b1);
        #2 iRstN = 1'b0;
        #1;
        chk("mid_async", {oBusy, oDone, oErr, oMemRe, oMemWe}, 5'b0);
        chk("mid_addr", oMemAddr, 16'h0000);
        chk("mid_wdata", oMemWdata, 8'h00);
        chk("mid_rdata", oRdata, 8'h00);
        @(negedge iClk);
        iRstN = 1'b1;
        step();
        chk("post_rst", {oBusy, oDone, oErr, oMemRe, oMemWe}, 5'b0);
        chk("post_rst_addr", oMemAddr, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
